sram_sp_be_ctrl: RTL and testbench

Parametrised single-port SRAM controller with byte enables. It sits between a SoC master-side request/response interface and an active-low single-port SRAM macro (CEN/GWEN/per-bit WEN/A/D/Q). It adds the following over a plain macro wrapper:
- valid/ready request handshake
- optional output pipeline register
- read-data hold
- hardware zero-fill of the array after reset or on request

---
 rtl/sram_ctrl_pkg.sv | 41 ++++
 rtl/sram_sp_be_model.sv | 36 +++
 rtl/sram_sp_be_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sram_sp_be_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the single-port byte-enable SRAM controller.
// Holds the FSM encoding, the byte-enable to bit-mask expansion and parameter checks.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StRst  = 2'd0,
    StInit = 2'd1,
    StRun  = 2'd2
  } state_e;

  // Widest data bus the mask helper can expand.
  localparam int unsigned MaxDataW = 256;

  // Active-high lane enables in, active-low per-bit write mask out (lanes past nb stay 1).
  function automatic logic [MaxDataW-1:0] be_to_wen(input logic [MaxDataW-1:0] be,
                                                     input int unsigned        nb,
                                                     input int unsigned        byte_w);
    logic [MaxDataW-1:0] wen;
    logic [MaxDataW-1:0] lmask;
    logic [MaxDataW-1:0] be_sh;
    wen   = '1;
    lmask = ~({MaxDataW{1'b1}} << byte_w);
    for (int unsigned lane = 0; lane < nb; lane++) begin
      be_sh = be >> lane;
      if (be_sh[0]) begin
        wen = wen & ~(lmask << (lane * byte_w));
      end
    end
    return wen;
  endfunction

  function automatic bit params_ok(input int unsigned data_w,
                                   input int unsigned byte_w,
                                   input int unsigned depth,
                                   input int unsigned addr_w);
    return (byte_w != 0) && (data_w != 0) && ((data_w % byte_w) == 0) &&
           (data_w <= MaxDataW) && (depth != 0) && (addr_w >= 1) && (addr_w < 64) &&
           (64'(depth) <= (64'd1 << addr_w));
  endfunction

endpackage

// File: rtl/sram_sp_be_model.sv
// Behavioural single-port array with active-low chip/global/per-bit write enables.
// Read data appears on o_q the cycle after a read edge and holds until the next read.
module sram_sp_be_model #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 16384
) (
  input  logic              i_clk,
  input  logic              i_cen,
  input  logic              i_gwen,
  input  logic [DATA_W-1:0] i_wen,
  input  logic [ADDR_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IdxW-1:0]   w_idx;
  logic              w_hit;

  assign w_idx = i_a[IdxW-1:0];
  assign w_hit = !i_cen && (32'(i_a) < DEPTH);

  always_ff @(posedge i_clk) begin
    if (w_hit) begin
      if (!i_gwen) begin
        r_mem[w_idx] <= (r_mem[w_idx] & i_wen) | (i_d & ~i_wen);
      end else begin
        o_q <= r_mem[w_idx];
      end
    end
  end

endmodule

// File: rtl/sram_sp_be_ctrl.sv
// Single-port SRAM controller: valid/ready requests, byte-enable writes, optional output
// register, read-data hold and a hardware zero-fill after reset or on request.
module sram_sp_be_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BYTE_W  = 8,
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned OUT_REG = 0,
  parameter int unsigned INIT_EN = 1,
  localparam int unsigned NB     = DATA_W / BYTE_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_req,
  output logic              init_done,
  output logic              mem_CEN,
  output logic              mem_GWEN,
  output logic [DATA_W-1:0] mem_WEN,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_D,
  input  logic [DATA_W-1:0] mem_Q
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DepthLim = (ADDR_W + 1)'(DEPTH);

  if (!params_ok(DATA_W, BYTE_W, DEPTH, ADDR_W)) begin : g_param_err
    $error("sram_sp_be_ctrl: illegal DATA_W/BYTE_W/DEPTH/ADDR_W combination");
  end

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  logic              w_run;
  logic              w_acc;
  logic              w_in_range;
  logic              w_rd;
  logic              w_mem_rd;
  logic              w_mem_wr;
  logic [DATA_W-1:0] w_wen_be;

  logic              r_rd_p1;
  logic              r_oor_p1;
  logic [DATA_W-1:0] w_rdata_p1;
  logic              w_rsp_valid;
  logic [DATA_W-1:0] w_rsp_data;
  logic [DATA_W-1:0] r_hold;

  assign w_run      = (r_state == StRun);
  assign w_acc      = req_valid & w_run;
  assign w_in_range = ({1'b0, req_addr} < DepthLim);
  assign w_rd       = w_acc & ~req_write;
  assign w_mem_rd   = w_rd & w_in_range;
  // Writes with no lane enabled or outside the array are swallowed without a macro access.
  assign w_mem_wr   = w_acc & req_write & w_in_range & (|req_be);
  assign w_wen_be   = DATA_W'(be_to_wen(MaxDataW'(req_be), NB, BYTE_W));

  assign req_ready  = w_run;
  assign init_done  = w_run;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StRst: begin
        w_state_nxt = (INIT_EN != 0) ? StInit : StRun;
      end
      StInit: begin
        if (r_cnt == LastAddr) begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      StRun: begin
        if (init_req) begin
          w_state_nxt = StInit;
        end
      end
      default: begin
        w_state_nxt = StRst;
      end
    endcase
  end

  always_comb begin
    mem_CEN  = 1'b1;
    mem_GWEN = 1'b1;
    mem_WEN  = '1;
    mem_A    = '0;
    mem_D    = '0;
    unique case (r_state)
      StInit: begin
        mem_CEN  = 1'b0;
        mem_GWEN = 1'b0;
        mem_WEN  = '0;
        mem_A    = r_cnt;
      end
      StRun: begin
        mem_CEN  = ~(w_mem_rd | w_mem_wr);
        mem_GWEN = ~(w_acc & req_write);
        mem_WEN  = (w_acc & req_write) ? w_wen_be : '1;
        mem_A    = req_addr;
        mem_D    = req_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state  <= StRst;
      r_cnt    <= '0;
      r_rd_p1  <= 1'b0;
      r_oor_p1 <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rd_p1  <= w_rd;
      r_oor_p1 <= w_rd & ~w_in_range;
      if (w_rsp_valid) begin
        r_hold <= w_rsp_data;
      end
    end
  end

  // Out-of-range reads never touched the macro, so mem_Q is stale and must be masked.
  assign w_rdata_p1 = r_oor_p1 ? '0 : mem_Q;

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_rd_p2;
    logic [DATA_W-1:0] r_q_p2;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        r_rd_p2 <= 1'b0;
        r_q_p2  <= '0;
      end else begin
        r_rd_p2 <= r_rd_p1;
        if (r_rd_p1) begin
          r_q_p2 <= w_rdata_p1;
        end
      end
    end

    assign w_rsp_valid = r_rd_p2;
    assign w_rsp_data  = r_q_p2;
  end else begin : g_no_out_reg
    assign w_rsp_valid = r_rd_p1;
    assign w_rsp_data  = w_rdata_p1;
  end

  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = w_rsp_valid ? w_rsp_data : r_hold;

endmodule

// File: tb/tb_sram_sp_be_ctrl.sv
// Bench for sram_sp_be_ctrl: two controllers (OUT_REG=0 and OUT_REG=1) share one stimulus
// stream, each backed by its own array model; expectations come from hand-built tables.
module tb_sram_sp_be_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DP = 16;

  typedef struct {
    logic          valid;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          init;
    logic          cen;
    logic          gwen;
    logic [DW-1:0] wen;
    logic          rv0;
    logic [DW-1:0] rd0;
    logic          rv1;
    logic [DW-1:0] rd1;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          init_req;

  logic          ready0, rv0, done0, cen0, gwen0;
  logic [DW-1:0] rd0, wen0, d0, q0;
  logic [AW-1:0] a0;
  logic          ready1, rv1, done1, cen1, gwen1;
  logic [DW-1:0] rd1, wen1, d1, q1;
  logic [AW-1:0] a1;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tab1 [20];
  vec_t tab2 [3];

  sram_sp_be_ctrl #(
    .DATA_W (DW), .BYTE_W (8), .DEPTH (DP), .ADDR_W (AW), .OUT_REG (0), .INIT_EN (1)
  ) u_dut0 (
    .CLK (clk), .RESETn (rst_n), .req_valid (req_valid), .req_ready (ready0),
    .req_write (req_write), .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (rv0), .rsp_rdata (rd0), .init_req (init_req), .init_done (done0),
    .mem_CEN (cen0), .mem_GWEN (gwen0), .mem_WEN (wen0), .mem_A (a0), .mem_D (d0),
    .mem_Q (q0)
  );

  sram_sp_be_model #(.DATA_W (DW), .ADDR_W (AW), .DEPTH (DP)) u_mem0 (
    .i_clk (clk), .i_cen (cen0), .i_gwen (gwen0), .i_wen (wen0), .i_a (a0), .i_d (d0),
    .o_q (q0)
  );

  sram_sp_be_ctrl #(
    .DATA_W (DW), .BYTE_W (8), .DEPTH (DP), .ADDR_W (AW), .OUT_REG (1), .INIT_EN (1)
  ) u_dut1 (
    .CLK (clk), .RESETn (rst_n), .req_valid (req_valid), .req_ready (ready1),
    .req_write (req_write), .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
    .rsp_valid (rv1), .rsp_rdata (rd1), .init_req (init_req), .init_done (done1),
    .mem_CEN (cen1), .mem_GWEN (gwen1), .mem_WEN (wen1), .mem_A (a1), .mem_D (d1),
    .mem_Q (q1)
  );

  sram_sp_be_model #(.DATA_W (DW), .ADDR_W (AW), .DEPTH (DP)) u_mem1 (
    .i_clk (clk), .i_cen (cen1), .i_gwen (gwen1), .i_wen (wen1), .i_a (a1), .i_d (d1),
    .o_q (q1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic valid, input logic write, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [3:0] be,
                              input logic init, input logic cen, input logic gwen,
                              input logic [DW-1:0] wen, input logic xrv0,
                              input logic [DW-1:0] xrd0, input logic xrv1,
                              input logic [DW-1:0] xrd1);
    vec_t v;
    v.valid = valid; v.write = write; v.addr = addr; v.wdata = wdata; v.be = be;
    v.init = init; v.cen = cen; v.gwen = gwen; v.wen = wen;
    v.rv0 = xrv0; v.rd0 = xrd0; v.rv1 = xrv1; v.rd1 = xrd1;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk_b({tag, ".ready0"}, ready0, 1'b0);
    chk_b({tag, ".rv0"},    rv0,    1'b0);
    chk_w({tag, ".rd0"},    rd0,    32'h0);
    chk_b({tag, ".done0"},  done0,  1'b0);
    chk_b({tag, ".cen0"},   cen0,   1'b1);
    chk_b({tag, ".gwen0"},  gwen0,  1'b1);
    chk_w({tag, ".wen0"},   wen0,   32'hFFFF_FFFF);
    chk_w({tag, ".a0"},     32'(a0), 32'h0);
    chk_w({tag, ".d0"},     d0,     32'h0);
    chk_b({tag, ".ready1"}, ready1, 1'b0);
    chk_b({tag, ".rv1"},    rv1,    1'b0);
    chk_w({tag, ".rd1"},    rd1,    32'h0);
    chk_b({tag, ".done1"},  done1,  1'b0);
    chk_b({tag, ".cen1"},   cen1,   1'b1);
    chk_b({tag, ".gwen1"},  gwen1,  1'b1);
    chk_w({tag, ".wen1"},   wen1,   32'hFFFF_FFFF);
    chk_w({tag, ".a1"},     32'(a1), 32'h0);
    chk_w({tag, ".d1"},     d1,     32'h0);
  endtask

  // Called at posedge+1 of the first fill cycle. A request and init_req are kept asserted
  // to show both are ignored while filling. pulse: a read was accepted just before the fill.
  task automatic fill_check(input string tag, input logic pulse, input logic [31:0] prev,
                            input logic [31:0] nv, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd1;
      req_wdata = 32'h0BAD_F00D; req_be = 4'hF; init_req = 1'b1;
      @(negedge clk);
      chk_b($sformatf("%s[%0d].cen0", tag, k),   cen0,   1'b0);
      chk_b($sformatf("%s[%0d].gwen0", tag, k),  gwen0,  1'b0);
      chk_w($sformatf("%s[%0d].wen0", tag, k),   wen0,   32'h0);
      chk_w($sformatf("%s[%0d].a0", tag, k),     32'(a0), 32'(k));
      chk_w($sformatf("%s[%0d].d0", tag, k),     d0,     32'h0);
      chk_b($sformatf("%s[%0d].ready0", tag, k), ready0, 1'b0);
      chk_b($sformatf("%s[%0d].done0", tag, k),  done0,  1'b0);
      chk_w($sformatf("%s[%0d].a1", tag, k),     32'(a1), 32'(k));
      chk_b($sformatf("%s[%0d].cen1", tag, k),   cen1,   1'b0);
      chk_b($sformatf("%s[%0d].done1", tag, k),  done1,  1'b0);
      chk_b($sformatf("%s[%0d].rv0", tag, k),    rv0,    pulse && (k == 0));
      chk_w($sformatf("%s[%0d].rd0", tag, k),    rd0,    pulse ? nv : prev);
      chk_b($sformatf("%s[%0d].rv1", tag, k),    rv1,    pulse && (k == 1));
      chk_w($sformatf("%s[%0d].rd1", tag, k),    rd1,    (pulse && (k >= 1)) ? nv : prev);
      @(posedge clk); #1;
    end
    if (ncyc == 16) begin
      req_valid = 1'b0; init_req = 1'b0;
      @(negedge clk);
      chk_b({tag, ".end.done0"},  done0,  1'b1);
      chk_b({tag, ".end.ready0"}, ready0, 1'b1);
      chk_b({tag, ".end.done1"},  done1,  1'b1);
      chk_b({tag, ".end.ready1"}, ready1, 1'b1);
      chk_b({tag, ".end.cen0"},   cen0,   1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    req_valid = v.valid; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_be = v.be; init_req = v.init;
    @(negedge clk);
    chk_b({tag, ".cen0"},   cen0,    v.cen);
    chk_b({tag, ".cen1"},   cen1,    v.cen);
    chk_b({tag, ".gwen0"},  gwen0,   v.gwen);
    chk_w({tag, ".wen0"},   wen0,    v.wen);
    chk_w({tag, ".a0"},     32'(a0), 32'(v.addr));
    chk_w({tag, ".d0"},     d0,      v.wdata);
    chk_b({tag, ".ready0"}, ready0,  1'b1);
    chk_b({tag, ".rv0"},    rv0,     v.rv0);
    chk_w({tag, ".rd0"},    rd0,     v.rd0);
    chk_b({tag, ".rv1"},    rv1,     v.rv1);
    chk_w({tag, ".rd1"},    rd1,     v.rd1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Fields: valid write addr wdata be init | cen gwen wen | rv0 rd0 | rv1 rd1
    tab1[0]  = mk(1'b1, 1'b0, 5'd5, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h0, 1'b0, 32'h0);
    tab1[1]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'h0, 1'b0, 32'h0);
    tab1[2]  = mk(1'b1, 1'b1, 5'd3, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b0, 32'h0, 1'b1, 32'h0);
    tab1[3]  = mk(1'b1, 1'b1, 5'd3, 32'h1122_3344, 4'h5, 1'b0, 1'b0, 1'b0, 32'hFF00_FF00,
                  1'b0, 32'h0, 1'b0, 32'h0);
    tab1[4]  = mk(1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h0, 1'b0, 32'h0);
    tab1[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'hA522_A544, 1'b0, 32'h0);
    tab1[6]  = mk(1'b1, 1'b1, 5'd0, 32'h10, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b0, 32'hA522_A544, 1'b1, 32'hA522_A544);
    tab1[7]  = mk(1'b1, 1'b1, 5'd1, 32'h11, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b0, 32'hA522_A544, 1'b0, 32'hA522_A544);
    tab1[8]  = mk(1'b1, 1'b1, 5'd2, 32'h12, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b0, 32'hA522_A544, 1'b0, 32'hA522_A544);
    tab1[9]  = mk(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'hA522_A544, 1'b0, 32'hA522_A544);
    tab1[10] = mk(1'b1, 1'b0, 5'd1, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'h10, 1'b0, 32'hA522_A544);
    tab1[11] = mk(1'b1, 1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'h11, 1'b1, 32'h10);
    tab1[12] = mk(1'b1, 1'b1, 5'd4, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b1, 32'h12, 1'b1, 32'h11);
    tab1[13] = mk(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h12, 1'b1, 32'h12);
    tab1[14] = mk(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF,
                  1'b0, 32'h12, 1'b0, 32'h12);
    tab1[15] = mk(1'b1, 1'b0, 5'd20, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h12, 1'b0, 32'h12);
    tab1[16] = mk(1'b1, 1'b0, 5'd7, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'h0, 1'b0, 32'h12);
    tab1[17] = mk(1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF,
                  1'b1, 32'h0, 1'b1, 32'h0);
    tab1[18] = mk(1'b1, 1'b1, 5'd20, 32'h55, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0,
                  1'b0, 32'h0, 1'b1, 32'h0);
    tab1[19] = mk(1'b1, 1'b0, 5'd2, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h0, 1'b0, 32'h0);

    tab2[0]  = mk(1'b1, 1'b0, 5'd2, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h12, 1'b0, 32'h12);
    tab2[1]  = mk(1'b1, 1'b1, 5'd3, 32'h77, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,
                  1'b1, 32'h0, 1'b0, 32'h12);
    tab2[2]  = mk(1'b1, 1'b0, 5'd3, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF,
                  1'b0, 32'h0, 1'b1, 32'h0);

    // Busy inputs during reset must not leak onto the macro pins.
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9;
    req_wdata = 32'hDEAD_BEEF; req_be = 4'hF; init_req = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rel");
    @(posedge clk); #1;
    fill_check("fill0", 1'b0, 32'h0, 32'h0, 16);

    for (int i = 0; i < 20; i++) apply_vec(tab1[i], $sformatf("t1[%0d]", i));
    fill_check("fill1", 1'b1, 32'h0, 32'h12, 16);

    for (int i = 0; i < 3; i++) apply_vec(tab2[i], $sformatf("t2[%0d]", i));
    fill_check("fill2", 1'b1, 32'h0, 32'h77, 8);

    // Reset lands in fill cycle 8; outputs must drop without waiting for an edge.
    rst_n = 1'b0;
    #1;
    check_reset("rst_fill");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rel2");
    @(posedge clk); #1;
    fill_check("fill3", 1'b0, 32'h0, 32'h0, 16);

    // Read accepted, then reset before its response: the response must vanish.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd3; req_wdata = 32'h0; req_be = 4'h0;
    init_req = 1'b0;
    @(negedge clk);
    chk_b("rd_drop.cen0", cen0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
